// File: rtl/sd_spi_pkg.sv
// Shared types, constants and CRC step functions for the
// SPI-mode SD command and data engines.
package sd_spi_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_SEND,
    S_WAIT_R1,
    S_READ_R1,
    S_READ_EXT,
    S_BUSY_WAIT,
    S_WAIT_TOKEN,
    S_READ_DATA,
    S_READ_CRC,
    S_TRAIL,
    S_DONE
  } state_e;

  localparam logic [1:0] RESP_R1  = 2'd0;
  localparam logic [1:0] RESP_R1B = 2'd1;
  localparam logic [1:0] RESP_R37 = 2'd2;

  localparam logic [7:0] DATA_TOKEN = 8'hFE;

  localparam int ERR_R1  = 2;
  localparam int ERR_TO  = 1;
  localparam int ERR_CRC = 0;

  localparam int FRAME_BITS   = 48;
  localparam int PAYLOAD_BITS = 40;
  localparam int TRAIL_CLKS   = 8;

  function automatic logic [6:0] crc7_next(
    input logic [6:0] crc,
    input logic       b
  );
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [15:0] crc16_next(
    input logic [15:0] crc,
    input logic        b
  );
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sd_spi_cmd_engine_crc16.sv
// Bit-serial CRC16-CCITT (init 0) with synchronous clear and
// enable; clear wins when both are asserted.
module sd_crc16
  import sd_spi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc16_next(crc_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD command engine: frames a command with CRC7, takes
// R1/R1b/R3/R7 responses and streams one CRC16-checked data block.
module sd_spi_cmd_engine
  import sd_spi_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int INIT_CLOCKS = 80,
  parameter int NCR_MAX     = 64,
  parameter int TOKEN_MAX   = 65536,
  parameter int BUSY_MAX    = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        init_req,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  resp_type,
  input  logic        data_read,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic [31:0] resp_ext,
  output logic [7:0]  data_byte,
  output logic        data_valid,
  output logic        crc_ok,
  output logic [2:0]  err,
  input  logic        miso,
  output logic        mosi,
  output logic        cs_n
);

  localparam int DATA_BITS = BLOCK_BYTES * 8;
  localparam int CNT_MAX = max_int(
    max_int(max_int(INIT_CLOCKS, NCR_MAX),
            max_int(TOKEN_MAX, BUSY_MAX)),
    max_int(DATA_BITS, FRAME_BITS));
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_CLOCKS - 1);
  localparam logic [CW-1:0] NCR_LAST   = CW'(NCR_MAX - 1);
  localparam logic [CW-1:0] TOKEN_LAST = CW'(TOKEN_MAX - 1);
  localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_MAX - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] PAY_END    = CW'(PAYLOAD_BITS);
  localparam logic [CW-1:0] R1_LAST    = CW'(6);
  localparam logic [CW-1:0] EXT_LAST   = CW'(31);
  localparam logic [CW-1:0] CRC_LAST   = CW'(15);
  localparam logic [CW-1:0] TRAIL_LAST = CW'(TRAIL_CLKS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [39:0]   cmd_q, cmd_d;
  logic [6:0]    crc7_q, crc7_d;
  logic [1:0]    rtype_q, rtype_d;
  logic          dread_q, dread_d;
  logic [7:0]    r1_q, r1_d;
  logic [31:0]   ext_q, ext_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic [15:0]   crcrx_q, crcrx_d;
  logic          crc_ok_q, crc_ok_d;
  logic [2:0]    err_q, err_d;

  logic          mosi_c;
  logic          crc16_clr;
  logic          crc16_en;
  logic [15:0]   crc16_val;
  logic [7:0]    r1_new;
  logic [7:0]    sh_new;
  logic [15:0]   crcrx_new;

  sd_crc16 u_crc16 (
    .clk   (clk),
    .reset (reset),
    .clr   (crc16_clr),
    .en    (crc16_en),
    .din   (miso),
    .crc   (crc16_val)
  );

  assign r1_new    = {r1_q[6:0], miso};
  assign sh_new    = {sh_q[6:0], miso};
  assign crcrx_new = {crcrx_q[14:0], miso};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    cmd_d     = cmd_q;
    crc7_d    = crc7_q;
    rtype_d   = rtype_q;
    dread_d   = dread_q;
    r1_d      = r1_q;
    ext_d     = ext_q;
    sh_d      = sh_q;
    byte_d    = byte_q;
    dv_d      = 1'b0;
    crcrx_d   = crcrx_q;
    crc_ok_d  = crc_ok_q;
    err_d     = err_q;
    mosi_c    = 1'b1;
    crc16_clr = 1'b0;
    crc16_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        crc16_clr = 1'b1;
        if (start) begin
          cmd_d    = {2'b01, cmd_index, cmd_arg};
          rtype_d  = resp_type;
          dread_d  = data_read;
          r1_d     = 8'hFF;
          err_d    = '0;
          crc_ok_d = 1'b0;
          crc7_d   = '0;
          state_d  = init_req ? S_INIT : S_SEND;
        end
      end
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // payload bits feed the CRC, then the CRC shifts out
        if (cnt_q < PAY_END) begin
          mosi_c = cmd_q[39];
          cmd_d  = {cmd_q[38:0], 1'b0};
          crc7_d = crc7_next(crc7_q, cmd_q[39]);
        end else if (cnt_q < FRAME_LAST) begin
          mosi_c = crc7_q[6];
          crc7_d = {crc7_q[5:0], 1'b0};
        end
        if (cnt_q == FRAME_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_R1;
        end
      end
      S_WAIT_R1: begin
        if (!miso) begin
          r1_d    = r1_new;
          cnt_d   = '0;
          state_d = S_READ_R1;
        end else if (cnt_q == NCR_LAST) begin
          err_d[ERR_TO] = 1'b1;
          cnt_d         = '0;
          state_d       = S_TRAIL;
        end
      end
      S_READ_R1: begin
        r1_d = r1_new;
        if (cnt_q == R1_LAST) begin
          cnt_d = '0;
          sh_d  = 8'hFF;
          if (|r1_new[6:1]) begin
            err_d[ERR_R1] = 1'b1;
            state_d       = S_TRAIL;
          end else if (rtype_q == RESP_R37) begin
            state_d = S_READ_EXT;
          end else if (rtype_q == RESP_R1B) begin
            state_d = S_BUSY_WAIT;
          end else if (dread_q) begin
            state_d = S_WAIT_TOKEN;
          end else begin
            state_d = S_TRAIL;
          end
        end
      end
      S_READ_EXT: begin
        ext_d = {ext_q[30:0], miso};
        if (cnt_q == EXT_LAST) begin
          cnt_d   = '0;
          sh_d    = 8'hFF;
          state_d = dread_q ? S_WAIT_TOKEN : S_TRAIL;
        end
      end
      S_BUSY_WAIT: begin
        if (miso) begin
          cnt_d   = '0;
          state_d = S_TRAIL;
        end else if (cnt_q == BUSY_LAST) begin
          err_d[ERR_TO] = 1'b1;
          cnt_d         = '0;
          state_d       = S_TRAIL;
        end
      end
      S_WAIT_TOKEN: begin
        sh_d = sh_new;
        if (sh_new == DATA_TOKEN) begin
          cnt_d   = '0;
          state_d = S_READ_DATA;
        end else if (cnt_q == TOKEN_LAST) begin
          err_d[ERR_TO] = 1'b1;
          cnt_d         = '0;
          state_d       = S_TRAIL;
        end
      end
      S_READ_DATA: begin
        sh_d     = sh_new;
        crc16_en = 1'b1;
        if (cnt_q[2:0] == 3'b111) begin
          byte_d = sh_new;
          dv_d   = 1'b1;
        end
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = S_READ_CRC;
        end
      end
      S_READ_CRC: begin
        crcrx_d = crcrx_new;
        if (cnt_q == CRC_LAST) begin
          cnt_d   = '0;
          state_d = S_TRAIL;
          if (crcrx_new == crc16_val) begin
            crc_ok_d = 1'b1;
          end else begin
            err_d[ERR_CRC] = 1'b1;
          end
        end
      end
      S_TRAIL: begin
        if (cnt_q == TRAIL_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d = '0;
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      crc7_q   <= '0;
      rtype_q  <= RESP_R1;
      dread_q  <= 1'b0;
      r1_q     <= 8'hFF;
      ext_q    <= '0;
      sh_q     <= 8'hFF;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      crcrx_q  <= '0;
      crc_ok_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      crc7_q   <= crc7_d;
      rtype_q  <= rtype_d;
      dread_q  <= dread_d;
      r1_q     <= r1_d;
      ext_q    <= ext_d;
      sh_q     <= sh_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      crcrx_q  <= crcrx_d;
      crc_ok_q <= crc_ok_d;
      err_q    <= err_d;
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign cs_n       = !(state_q inside {S_SEND, S_WAIT_R1, S_READ_R1,
                                        S_READ_EXT, S_BUSY_WAIT,
                                        S_WAIT_TOKEN, S_READ_DATA,
                                        S_READ_CRC});
  assign mosi       = mosi_c;
  assign r1         = r1_q;
  assign resp_ext   = ext_q;
  assign data_byte  = byte_q;
  assign data_valid = dv_q;
  assign crc_ok     = crc_ok_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Bench for sd_spi_cmd_engine: scripted SPI card model plus
// scoreboards for command frames and data bytes.
module tb_sd_spi_cmd_engine;

  localparam int BB  = 4;
  localparam int NCR = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        init_req = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [1:0]  resp_type = '0;
  logic        data_read = 1'b0;
  logic        miso = 1'b1;
  logic        busy, done, data_valid, crc_ok, mosi, cs_n;
  logic [7:0]  r1, data_byte;
  logic [31:0] resp_ext;
  logic [2:0]  err;

  always #5 clk = ~clk;

  sd_spi_cmd_engine #(
    .BLOCK_BYTES (BB),
    .INIT_CLOCKS (80),
    .NCR_MAX     (NCR),
    .TOKEN_MAX   (65536),
    .BUSY_MAX    (65536)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .init_req   (init_req),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .resp_type  (resp_type),
    .data_read  (data_read),
    .busy       (busy),
    .done       (done),
    .r1         (r1),
    .resp_ext   (resp_ext),
    .data_byte  (data_byte),
    .data_valid (data_valid),
    .crc_ok     (crc_ok),
    .err        (err),
    .miso       (miso),
    .mosi       (mosi),
    .cs_n       (cs_n)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit          reply_q[$];
  logic [47:0] exp_frame[$];
  logic [7:0]  exp_data[$];
  logic [47:0] rx_frame = '0;
  logic [47:0] exp_f;
  logic [7:0]  exp_b;
  int  card_cnt = 0;
  bit  frame_seen = 0;
  int  post_lo = 0;
  int  post_hi = 0;
  int  pre_hi = 0;
  int  dv_cnt = 0;
  int  mosi_bad = 0;

  // card model and output monitors, all on the falling edge
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cnt++;
      n_cmp++;
      if (exp_data.size() == 0) begin
        n_bad++;
        $display("FAIL data_unexpected got %02h want none", data_byte);
      end else begin
        exp_b = exp_data.pop_front();
        if (data_byte !== exp_b) begin
          n_bad++;
          $display("FAIL data_byte got %02h want %02h", data_byte, exp_b);
        end
      end
    end
    if (cs_n === 1'b1 && mosi !== 1'b1) mosi_bad++;
    if (busy === 1'b1 && cs_n === 1'b1) begin
      if (frame_seen) post_hi++;
      else pre_hi++;
    end
    if (cs_n !== 1'b0) begin
      card_cnt = 0;
      miso = 1'b1;
    end else if (card_cnt < 48) begin
      rx_frame = {rx_frame[46:0], mosi};
      card_cnt++;
      miso = 1'b1;
      if (card_cnt == 48) begin
        frame_seen = 1;
        n_cmp++;
        if (exp_frame.size() == 0) begin
          n_bad++;
          $display("FAIL frame_unexpected got %012h", rx_frame);
        end else begin
          exp_f = exp_frame.pop_front();
          if (rx_frame !== exp_f) begin
            n_bad++;
            $display("FAIL frame got %012h want %012h", rx_frame, exp_f);
          end
        end
      end
    end else begin
      post_lo++;
      miso = (reply_q.size() != 0) ? reply_q.pop_front() : 1'b1;
    end
  end

  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [6:0] c = '0;
    for (int i = 39; i >= 0; i--) begin
      logic fb = c[6] ^ d[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [15:0] ref_crc16(input logic [31:0] d);
    logic [15:0] c = '0;
    for (int i = 31; i >= 0; i--) begin
      logic fb = c[15] ^ d[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_crc(
    input logic [5:0] idx, input logic [31:0] arg);
    return {ref_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic push_ones(input int n);
    for (int i = 0; i < n; i++) reply_q.push_back(1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) reply_q.push_back(b[i]);
  endtask

  task automatic issue(
    input logic [5:0]  idx,
    input logic [31:0] arg,
    input logic [7:0]  crc_byte,
    input logic [1:0]  rt,
    input logic        dr,
    input logic        ini
  );
    exp_frame.push_back({2'b01, idx, arg, crc_byte});
    @(negedge clk);
    cmd_index = idx;
    cmd_arg = arg;
    resp_type = rt;
    data_read = dr;
    init_req = ini;
    post_lo = 0;
    post_hi = 0;
    pre_hi = 0;
    dv_cnt = 0;
    frame_seen = 0;
    start = 1'b1;
    for (int k = 0; k < 800 && done !== 1'b1; k++) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_wait got done=%b want 1 within 800 clks", done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || cs_n !== 1'b1) begin
      n_bad++;
      $display("FAIL done_hold got done=%b busy=%b cs_n=%b want 1 0 1",
               done, busy, cs_n);
    end
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_return got done=%b busy=%b want 0 0", done, busy);
    end
    reply_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (r1 !== 8'hFF || resp_ext !== 32'h0 || err !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_regs got r1=%h ext=%h err=%b want ff 0 000",
               r1, resp_ext, err);
    end
    n_cmp++;
    if (crc_ok !== 1'b0 || data_valid !== 1'b0 || data_byte !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data got ok=%b dv=%b byte=%h want 0 0 00",
               crc_ok, data_valid, data_byte);
    end
    n_cmp++;
    if (cs_n !== 1'b1 || mosi !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pins got cs_n=%b mosi=%b busy=%b done=%b want 1 1 0 0",
               cs_n, mosi, busy, done);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cmd0_init();
    push_ones(2);
    push_byte(8'h01);
    issue(6'd0, 32'h0, 8'h95, 2'd0, 1'b0, 1'b1);
    n_cmp++;
    if (pre_hi !== 80) begin
      n_bad++;
      $display("FAIL init_clocks got %0d want 80", pre_hi);
    end
    n_cmp++;
    if (r1 !== 8'h01 || err !== 3'b000) begin
      n_bad++;
      $display("FAIL cmd0_r1 got r1=%h err=%b want 01 000", r1, err);
    end
    n_cmp++;
    if (post_lo !== 10 || post_hi !== 8) begin
      n_bad++;
      $display("FAIL cmd0_timing got lo=%0d trail=%0d want 10 8",
               post_lo, post_hi);
    end
  endtask

  task automatic test_cmd8_r7();
    push_ones(1);
    push_byte(8'h01);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h01);
    push_byte(8'hAA);
    issue(6'd8, 32'h0000_01AA, 8'h87, 2'd2, 1'b0, 1'b0);
    n_cmp++;
    if (resp_ext !== 32'h0000_01AA || r1 !== 8'h01) begin
      n_bad++;
      $display("FAIL cmd8_resp got ext=%h r1=%h want 000001aa 01",
               resp_ext, r1);
    end
    n_cmp++;
    if (err !== 3'b000 || pre_hi !== 0 || post_lo !== 41) begin
      n_bad++;
      $display("FAIL cmd8_misc got err=%b init=%0d lo=%0d want 000 0 41",
               err, pre_hi, post_lo);
    end
  endtask

  task automatic test_read_block(input logic flip);
    logic [31:0] blk;
    logic [15:0] c;
    blk = 32'h0102_0304;
    c = ref_crc16(blk) ^ {15'h0, flip};
    push_ones(2);
    push_byte(8'h00);
    for (int i = 0; i < 5; i++) push_byte(8'hFF);
    push_byte(8'hFE);
    for (int i = 3; i >= 0; i--) begin
      push_byte(blk[i*8 +: 8]);
      exp_data.push_back(blk[i*8 +: 8]);
    end
    push_byte(c[15:8]);
    push_byte(c[7:0]);
    issue(6'd17, 32'h0, frame_crc(6'd17, 32'h0), 2'd0, 1'b1, 1'b0);
    n_cmp++;
    if (dv_cnt !== BB || exp_data.size() != 0) begin
      n_bad++;
      $display("FAIL read_strobes got %0d left=%0d want %0d 0",
               dv_cnt, exp_data.size(), BB);
    end
    n_cmp++;
    if (crc_ok !== !flip || err !== {2'b00, flip}) begin
      n_bad++;
      $display("FAIL read_crc got ok=%b err=%b want %b %b",
               crc_ok, err, !flip, {2'b00, flip});
    end
    n_cmp++;
    if (post_lo !== 106) begin
      n_bad++;
      $display("FAIL read_timing got lo=%0d want 106", post_lo);
    end
    exp_data.delete();
  endtask

  task automatic test_ncr_timeout();
    issue(6'd1, 32'h0, frame_crc(6'd1, 32'h0), 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (err !== 3'b010 || r1 !== 8'hFF) begin
      n_bad++;
      $display("FAIL ncr_timeout got err=%b r1=%h want 010 ff", err, r1);
    end
    n_cmp++;
    if (post_lo !== NCR || post_hi !== 8) begin
      n_bad++;
      $display("FAIL ncr_timing got lo=%0d trail=%0d want %0d 8",
               post_lo, post_hi, NCR);
    end
  endtask

  task automatic test_ncr_edge();
    push_ones(NCR - 1);
    push_byte(8'h01);
    issue(6'd55, 32'h0, frame_crc(6'd55, 32'h0), 2'd0, 1'b0, 1'b0);
    n_cmp++;
    if (err !== 3'b000 || r1 !== 8'h01 || post_lo !== NCR + 7) begin
      n_bad++;
      $display("FAIL ncr_edge got err=%b r1=%h lo=%0d want 000 01 %0d",
               err, r1, post_lo, NCR + 7);
    end
  endtask

  task automatic test_illegal();
    push_ones(1);
    push_byte(8'h04);
    push_ones(16);
    push_byte(8'hFE);
    push_byte(8'h55);
    issue(6'd17, 32'h200, frame_crc(6'd17, 32'h200), 2'd0, 1'b1, 1'b0);
    n_cmp++;
    if (err !== 3'b100 || r1 !== 8'h04) begin
      n_bad++;
      $display("FAIL illegal_err got err=%b r1=%h want 100 04", err, r1);
    end
    n_cmp++;
    if (dv_cnt !== 0 || post_lo !== 9) begin
      n_bad++;
      $display("FAIL illegal_flow got dv=%0d lo=%0d want 0 9",
               dv_cnt, post_lo);
    end
  endtask

  task automatic test_r1b_busy();
    push_ones(1);
    push_byte(8'h00);
    for (int i = 0; i < 100; i++) reply_q.push_back(1'b0);
    push_ones(1);
    issue(6'd12, 32'h0, frame_crc(6'd12, 32'h0), 2'd1, 1'b0, 1'b0);
    n_cmp++;
    if (err !== 3'b000 || r1 !== 8'h00 || post_lo !== 110) begin
      n_bad++;
      $display("FAIL r1b_busy got err=%b r1=%h lo=%0d want 000 00 110",
               err, r1, post_lo);
    end
  endtask

  task automatic test_reset_mid_read();
    push_ones(1);
    push_byte(8'h00);
    push_byte(8'hFE);
    for (int i = 0; i < BB + 2; i++) begin
      push_byte(8'hA0 + 8'(i));
      if (i < BB) exp_data.push_back(8'hA0 + 8'(i));
    end
    exp_frame.push_back({2'b01, 6'd17, 32'h0, frame_crc(6'd17, 32'h0)});
    @(negedge clk);
    cmd_index = 6'd17;
    cmd_arg = 32'h0;
    resp_type = 2'd0;
    data_read = 1'b1;
    init_req = 1'b0;
    dv_cnt = 0;
    start = 1'b1;
    for (int k = 0; k < 400 && dv_cnt == 0; k++) @(negedge clk);
    n_cmp++;
    if (dv_cnt == 0) begin
      n_bad++;
      $display("FAIL mid_read_wait got dv=0 want a strobe within 400 clks");
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || cs_n !== 1'b1 || mosi !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_pins got busy=%b cs_n=%b mosi=%b want 0 1 1",
               busy, cs_n, mosi);
    end
    n_cmp++;
    if (r1 !== 8'hFF || data_valid !== 1'b0 || err !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset_regs got r1=%h dv=%b err=%b want ff 0 000",
               r1, data_valid, err);
    end
    start = 1'b0;
    reset = 1'b1;
    reply_q.delete();
    exp_data.delete();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mosi_bad !== 0) begin
      n_bad++;
      $display("FAIL mosi_idle got %0d bad clks want 0", mosi_bad);
    end
  endtask

  initial begin
    test_reset();
    test_cmd0_init();
    test_cmd8_r7();
    test_read_block(1'b0);
    test_read_block(1'b1);
    test_ncr_timeout();
    test_ncr_edge();
    test_illegal();
    test_r1b_busy();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_spi_cmd_engine.md
Name: sd_spi_cmd_engine

Overview:
Parametrised SPI-mode SD command engine. It generates the CRC7 internally, frames and shifts a 48-bit command, and captures the R1, R1b, R3 or R7 response. For single-block reads it also hunts for the start token, streams the data block byte-wise and checks its CRC16. It sits between the card-init/read controller FSM and the SPI pins; one bit is transferred per clk, and SCLK is generated externally from clk.

Parameters:
BLOCK_BYTES, 512, data block length in bytes (1..4096).
INIT_CLOCKS, 80, clocks with cs_n=1 and mosi=1 sent when init_req is set.
NCR_MAX, 64, maximum clocks from the end of the command to the R1 start bit.
TOKEN_MAX, 65536, maximum clocks from the end of R1 to the data token.
BUSY_MAX, 65536, maximum clocks of R1b busy (miso low).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
start  in  1  level request; sampled only in IDLE
init_req  in  1  prepend INIT_CLOCKS idle clocks
cmd_index  in  6  command index
cmd_arg  in  32  command argument
resp_type  in  2  0=R1, 1=R1b, 2=R3/R7 (R1 plus 32 bits)
data_read  in  1  expect a data block after R1
busy  out  1  high whenever state != IDLE and state != DONE
done  out  1  high in DONE
r1  out  8  captured R1
resp_ext  out  32  R3/R7 payload, MSB first
data_byte  out  8  received data byte
data_valid  out  1  one-cycle strobe per byte; no backpressure
crc_ok  out  1  received CRC16 equals computed CRC16
err  out  3  {r1_err, timeout, crc_err}
miso  in  1  card DO
mosi  out  1  card DI
cs_n  out  1  card chip select, active-low

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, all counters 0.
  - r1=8'hFF, resp_ext=0, data_byte=0, err=0, crc_ok=0, data_valid=0.
  - cs_n=1, mosi=1.
  - Reset mid-operation aborts immediately with the same values; there is no trailing-clock sequence.
- States: IDLE, INIT, SEND, WAIT_R1, READ_R1, READ_EXT, BUSY_WAIT, WAIT_TOKEN, READ_DATA, READ_CRC, TRAIL, DONE.
- Outputs per state:
  - cs_n=0 in SEND through READ_CRC; cs_n=1 elsewhere.
  - mosi=1 in every state except SEND.
- IDLE: on start=1, latch all request inputs and clear err/crc_ok. Go to INIT if init_req, else SEND.
- INIT: INIT_CLOCKS cycles, then SEND.
- SEND: 48 cycles. The frame is {2'b01, cmd_index, cmd_arg, crc7, 1'b1}.
  - Frame bit 47-n is driven on mosi in cycle n (MSB first, combinational from the bit counter).
  - crc7 uses polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
- WAIT_R1: miso is sampled each clk.
  - The first 0 becomes r1[7]; go to READ_R1.
  - After NCR_MAX cycles without a 0: timeout=1, go to TRAIL.
- READ_R1: 7 cycles fill r1[6:0], MSB first. Then:
  - r1[6:1] != 0: r1_err=1, skip ext/busy/data, go to TRAIL. Idle bit r1[0] is not an error.
  - Otherwise: resp_type=2 → READ_EXT; resp_type=1 → BUSY_WAIT; data_read → WAIT_TOKEN; else TRAIL.
- READ_EXT: 32 cycles, MSB first, into resp_ext. Then WAIT_TOKEN if data_read, else TRAIL.
- BUSY_WAIT: exit to TRAIL on the first miso=1. After BUSY_MAX cycles: timeout=1, go to TRAIL.
- WAIT_TOKEN: 8-bit shift register of miso, reset to 8'hFF on entry.
  - Register equals 8'hFE (including the bit just shifted): go to READ_DATA.
  - After TOKEN_MAX cycles: timeout=1, go to TRAIL.
- READ_DATA: BLOCK_BYTES*8 cycles.
  - After each 8th bit, data_byte and data_valid=1 are presented in the following cycle.
  - CRC16-CCITT (x^16+x^12+x^5+1, init 0) is updated per bit.
- READ_CRC: 16 cycles capture the card CRC.
  - crc_ok=1 iff the captured and computed values are equal; else crc_err=1.
  - The last data_valid pulse occurs in the first READ_CRC cycle.
- TRAIL: 8 cycles with cs_n=1 and mosi=1 (Nec), then DONE.
- DONE: done=1; r1/resp_ext/err are held stable. Return to IDLE when start=0. start held high does not retrigger.
- Width rules:
  - Counters are sized from the parameters with $clog2(max+1).
  - A count of exactly NCR_MAX/TOKEN_MAX/BUSY_MAX cycles is a timeout; the limit minus 1 is not.

Decomposition:
- Package sd_spi_pkg holds:
  - the state enum and resp_type encodings (RESP_R1, RESP_R1B, RESP_R37);
  - the token constant 8'hFE and the err bit indices;
  - functions crc7_next(crc, bit) and crc16_next(crc, bit), shared with future write-path blocks.
- Sub-module sd_crc16: bit-serial CRC16 with clear/enable. Reused by the write engine.

Test Plan:
1. CMD0 with init_req=1, arg 0, card returns 8'h01 → 80 idle clocks, then mosi frame 40 00 00 00 00 95; r1=8'h01, err=0, done=1.
2. CMD8, resp_type=2, arg 32'h000001AA → frame 48 00 00 01 AA 87; card replies 01 000001AA → resp_ext=32'h000001AA.
3. CMD17, BLOCK_BYTES=4, data 01 02 03 04 with correct CRC after token FE with 5 FF gap bytes → four data_valid strobes with values 01..04 in order; crc_ok=1. Repeat with CRC bit 0 flipped → crc_ok=0, crc_err=1.
4. Card never drives miso low → timeout=1 after exactly NCR_MAX cycles in WAIT_R1; 8 trailing clocks; cs_n=1 in DONE.
5. CMD17, R1=8'h04 (illegal command) → r1_err=1; no data_valid; no WAIT_TOKEN entry.
6. R1b with miso held low 100 cycles, and separately reset=0 mid-READ_DATA → busy exit after the first miso=1; reset case returns to IDLE next cycle with cs_n=1 and mosi=1.
